// File: rtl/zx8x_pkg.sv
// Shared definitions for the ZX80/ZX81 core: tape loader states, ROM
// entry/exit points of the LOAD routine, image base addresses and the
// opcodes of the spin-loop patch overlaid on the ROM.
package zx8x_pkg;

    // LOAD routine entry and first address past the patched window
    localparam logic [15:0] ZX81_ENTRY = 16'h0347;
    localparam logic [15:0] ZX81_EXIT  = 16'h03C3;
    localparam logic [15:0] ZX80_ENTRY = 16'h0207;
    localparam logic [15:0] ZX80_EXIT  = 16'h024D;

    // Load address of byte 0 of the image: .o files start at the system
    // variables, .p files skip the first nine bytes of them
    localparam logic [15:0] BASE_O = 16'h4000;
    localparam logic [15:0] BASE_P = 16'h4009;

    // Spin-loop patch: xor a / nop|scf / jr nc,-3 / jp <LOAD continuation>
    localparam logic [7:0] OP_XOR_A      = 8'hAF;
    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_SCF        = 8'h37;
    localparam logic [7:0] OP_JR_NC      = 8'h30;
    localparam logic [7:0] OP_JR_DISP    = 8'hFD;
    localparam logic [7:0] OP_JP         = 8'hC3;
    localparam logic [7:0] OP_JP_LO_ZX81 = 8'h07;
    localparam logic [7:0] OP_JP_LO_ZX80 = 8'h03;
    localparam logic [7:0] OP_JP_HI      = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,   // no tape held
        S_ARMED,  // tape held, waiting for the LOAD entry fetch
        S_FETCH,  // tape buffer address presented
        S_LATCH,  // buffer data captured into the write register
        S_WRITE,  // write request raised, waiting for the acknowledge
        S_DONE    // copy complete, waiting for the CPU to leave the window
    } tl_state_t;

    function automatic logic [15:0] entry_addr(input logic is_zx81);
        return is_zx81 ? ZX81_ENTRY : ZX80_ENTRY;
    endfunction

    function automatic logic [15:0] exit_addr(input logic is_zx81);
        return is_zx81 ? ZX81_EXIT : ZX80_EXIT;
    endfunction

    function automatic logic [15:0] base_addr(input logic is_p);
        return is_p ? BASE_P : BASE_O;
    endfunction

endpackage

// File: rtl/tape_load_ctrl_if.sv
// Memory-side bundle of the tape loader: read port of the tape buffer
// (synchronous, one-cycle latency) and the request/acknowledge write port
// into SDRAM. The loader is the master of both.
interface tape_load_ctrl_if;

    logic [13:0] tape_rd_addr;
    logic [7:0]  tape_rd_data;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_req;
    logic        ram_ack;

    modport master (
        output tape_rd_addr,
        input  tape_rd_data,
        output ram_addr,
        output ram_din,
        output ram_req,
        input  ram_ack
    );

    modport slave (
        input  tape_rd_addr,
        output tape_rd_data,
        input  ram_addr,
        input  ram_din,
        input  ram_req,
        output ram_ack
    );

endinterface

// File: rtl/tape_load_ctrl.sv
// Instant tape loader. Once an image is held it waits for the CPU to fetch
// the ROM LOAD entry, overlays a spin loop on the ROM, copies the tape
// buffer into SDRAM one byte at a time and then turns the loop's nop into
// scf so the CPU falls through into the rest of LOAD.
module tape_load_ctrl
    import zx8x_pkg::*;
(
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                zx81,
    input  logic                dl_start,
    input  logic                dl_done,
    input  logic                file_p,
    input  logic [14:0]         tape_len,
    input  logic [15:0]         cpu_addr,
    input  logic                cpu_m1_n,
    tape_load_ctrl_if.master    mem_if,
    output logic                patch_active,
    output logic [7:0]          patch_byte,
    output logic                tape_ready
);

    tl_state_t   state_q, state_d;
    logic        m1_q;
    logic [14:0] n_q, n_d;
    logic [14:0] len_q, len_d;
    logic        file_p_q, file_p_d;
    logic        model_q, model_d;
    logic        tape_ready_q, tape_ready_d;
    logic        patch_active_q, patch_active_d;
    logic        ram_req_q, ram_req_d;
    logic        abort_q, abort_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_din_q, ram_din_d;

    logic        m1_event;
    logic        entry_hit;
    logic        exit_hit;
    logic [15:0] entry_cur;
    logic [15:0] exit_cur;
    logic [15:0] offset;
    logic [14:0] n_inc;

    // Decode M1 events and classify them against the patch window
    always_comb begin
        entry_cur = entry_addr(model_q);
        exit_cur  = exit_addr(model_q);
        m1_event  = m1_q && !cpu_m1_n;
        // The entry test uses the live model input: the model is only
        // latched once the entry fetch has been recognised.
        entry_hit = m1_event && (cpu_addr == entry_addr(zx81));
        exit_hit  = m1_event && ((cpu_addr >= exit_cur) || (cpu_addr < entry_cur));
        n_inc     = n_q + 15'd1;
    end

    // Next-state and datapath update for the copy sequencer
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case below can leave one unassigned and infer a latch.
        state_d        = state_q;
        n_d            = n_q;
        len_d          = len_q;
        file_p_d       = file_p_q;
        model_d        = model_q;
        tape_ready_d   = tape_ready_q;
        patch_active_d = patch_active_q;
        ram_req_d      = ram_req_q;
        abort_d        = abort_q;
        ram_addr_d     = ram_addr_q;
        ram_din_d      = ram_din_q;

        unique case (state_q)
            S_IDLE: begin
                if (dl_done) begin
                    state_d      = S_ARMED;
                    len_d        = tape_len;
                    file_p_d     = file_p;
                    tape_ready_d = 1'b1;
                end
            end

            S_ARMED: begin
                if (entry_hit) begin
                    n_d            = '0;
                    model_d        = zx81;
                    patch_active_d = 1'b1;
                    abort_d        = 1'b0;
                    state_d        = (len_q == '0) ? S_DONE : S_FETCH;
                end else if (dl_done) begin
                    len_d    = tape_len;
                    file_p_d = file_p;
                end
            end

            S_FETCH: begin
                if (exit_hit) begin
                    state_d        = S_ARMED;
                    patch_active_d = 1'b0;
                end else begin
                    state_d = S_LATCH;
                end
            end

            S_LATCH: begin
                if (exit_hit) begin
                    state_d        = S_ARMED;
                    patch_active_d = 1'b0;
                end else begin
                    // Address and data are frozen here and stay put for the
                    // whole time the request is outstanding.
                    state_d    = S_WRITE;
                    ram_req_d  = 1'b1;
                    ram_din_d  = mem_if.tape_rd_data;
                    ram_addr_d = base_addr(file_p_q) + {1'b0, n_q};
                end
            end

            S_WRITE: begin
                if (mem_if.ram_ack) begin
                    ram_req_d = 1'b0;
                    n_d       = n_inc;
                    if (abort_q || exit_hit) begin
                        state_d        = S_ARMED;
                        patch_active_d = 1'b0;
                        abort_d        = 1'b0;
                    end else if (n_inc == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (exit_hit) begin
                    // A write already requested must complete before the
                    // abort takes effect; remember it until the ack.
                    abort_d = 1'b1;
                end
            end

            S_DONE: begin
                if (exit_hit) begin
                    state_d        = S_ARMED;
                    patch_active_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new download invalidates the held image and any copy in flight.
        if (dl_start) begin
            state_d        = S_IDLE;
            tape_ready_d   = 1'b0;
            patch_active_d = 1'b0;
            ram_req_d      = 1'b0;
            abort_d        = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_sys) begin
        // NOTE: non-blocking assignments so every register samples the
        // values from before this edge, whatever the statement order.
        if (reset) begin
            state_q        <= S_IDLE;
            m1_q           <= 1'b1;
            n_q            <= '0;
            len_q          <= '0;
            file_p_q       <= 1'b0;
            model_q        <= 1'b0;
            tape_ready_q   <= 1'b0;
            patch_active_q <= 1'b0;
            ram_req_q      <= 1'b0;
            abort_q        <= 1'b0;
            ram_addr_q     <= '0;
            ram_din_q      <= '0;
        end else begin
            state_q        <= state_d;
            m1_q           <= cpu_m1_n;
            n_q            <= n_d;
            len_q          <= len_d;
            file_p_q       <= file_p_d;
            model_q        <= model_d;
            tape_ready_q   <= tape_ready_d;
            patch_active_q <= patch_active_d;
            ram_req_q      <= ram_req_d;
            abort_q        <= abort_d;
            ram_addr_q     <= ram_addr_d;
            ram_din_q      <= ram_din_d;
        end
    end

    // Patch ROM: byte for the current CPU address, relative to the entry
    always_comb begin
        offset     = cpu_addr - entry_cur;
        patch_byte = OP_NOP;
        case (offset)
            16'd0:   patch_byte = OP_XOR_A;
            // nop keeps carry clear so jr nc spins; scf releases the loop
            16'd1:   patch_byte = (state_q == S_DONE) ? OP_SCF : OP_NOP;
            16'd2:   patch_byte = OP_JR_NC;
            16'd3:   patch_byte = OP_JR_DISP;
            16'd4:   patch_byte = OP_JP;
            16'd5:   patch_byte = model_q ? OP_JP_LO_ZX81 : OP_JP_LO_ZX80;
            16'd6:   patch_byte = OP_JP_HI;
            default: patch_byte = OP_NOP;
        endcase
    end

    assign mem_if.tape_rd_addr = n_q[13:0];
    assign mem_if.ram_addr     = ram_addr_q;
    assign mem_if.ram_din      = ram_din_q;
    assign mem_if.ram_req      = ram_req_q;
    assign patch_active        = patch_active_q;
    assign tape_ready          = tape_ready_q;

endmodule

// File: tb/tb_tape_load_ctrl.sv
// Bench for tape_load_ctrl: a tape buffer model and an SDRAM acknowledge
// responder surround the DUT; expected writes are queued by the stimulus
// and popped by an independent monitor on every accepted write.
module tb_tape_load_ctrl;

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic        zx81     = 1'b1;
    logic        dl_start = 1'b0;
    logic        dl_done  = 1'b0;
    logic        file_p   = 1'b0;
    logic [14:0] tape_len = '0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_m1_n = 1'b1;
    logic        patch_active;
    logic [7:0]  patch_byte;
    logic        tape_ready;

    tape_load_ctrl_if bus ();

    tape_load_ctrl dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .zx81         (zx81),
        .dl_start     (dl_start),
        .dl_done      (dl_done),
        .file_p       (file_p),
        .tape_len     (tape_len),
        .cpu_addr     (cpu_addr),
        .cpu_m1_n     (cpu_m1_n),
        .mem_if       (bus),
        .patch_active (patch_active),
        .patch_byte   (patch_byte),
        .tape_ready   (tape_ready)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    int         checks      = 0;
    int         failures    = 0;
    int         writes_seen = 0;
    int         ack_delay   = 0;
    logic [7:0] tape_mem [0:15];

    // Tape buffer: synchronous read, one cycle of latency
    always_ff @(posedge clk_sys) bus.tape_rd_data <= tape_mem[bus.tape_rd_addr[3:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // SDRAM side: acknowledge each request after ack_delay cycles
    initial begin : responder
        bus.ram_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (bus.ram_req) begin
                repeat (ack_delay) @(negedge clk_sys);
                bus.ram_ack = 1'b1;
                @(negedge clk_sys);
                bus.ram_ack = 1'b0;
            end
        end
    end

    // Monitor: stability while requesting, scoreboard compare on acceptance
    initial begin : monitor
        logic [15:0] cap_addr;
        logic [7:0]  cap_din;
        logic        req_prev;
        wr_t         e;
        req_prev = 1'b0;
        cap_addr = '0;
        cap_din  = '0;
        forever begin
            @(negedge clk_sys);
            #1;
            if (bus.ram_req) begin
                if (!req_prev) begin
                    cap_addr = bus.ram_addr;
                    cap_din  = bus.ram_din;
                end else begin
                    check("hold_addr", bus.ram_addr, cap_addr);
                    check("hold_din", bus.ram_din, cap_din);
                end
                if (bus.ram_ack) begin
                    writes_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: got %h/%h, want no write",
                                 bus.ram_addr, bus.ram_din);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", bus.ram_addr, e.addr);
                        check("wr_data", bus.ram_din, e.data);
                    end
                end
            end
            req_prev = bus.ram_req;
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge clk_sys);
    endtask

    task automatic load_tape(input logic p, input logic [14:0] len);
        @(negedge clk_sys);
        file_p   = p;
        tape_len = len;
        dl_done  = 1'b1;
        @(negedge clk_sys);
        dl_done  = 1'b0;
    endtask

    task automatic m1_fetch(input logic [15:0] a);
        @(negedge clk_sys);
        cpu_addr = a;
        cpu_m1_n = 1'b0;
        @(negedge clk_sys);
        cpu_m1_n = 1'b1;
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic check_patch(input string name, input logic [15:0] a, input logic [7:0] exp);
        cpu_addr = a;
        #1;
        check(name, patch_byte, exp);
    endtask

    task automatic wait_writes(input string name, input int target);
        int cyc;
        cyc = 0;
        while (writes_seen < target && cyc < 200) begin
            @(negedge clk_sys);
            cyc++;
        end
        check(name, writes_seen, target);
    endtask

    task automatic wait_req(input string name);
        int cyc;
        cyc = 0;
        while (!bus.ram_req && cyc < 50) begin
            @(negedge clk_sys);
            cyc++;
        end
        check(name, bus.ram_req, 1);
    endtask

    initial begin : stimulus
        int base;
        for (int i = 0; i < 16; i++) tape_mem[i] = 8'((i + 1) * 17);  // 11,22,33,...

        // Reset state
        cycles(3);
        check("rst_patch_active", patch_active, 0);
        check("rst_tape_ready", tape_ready, 0);
        check("rst_ram_req", bus.ram_req, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_din", bus.ram_din, 0);
        check("rst_tape_rd_addr", bus.tape_rd_addr, 0);
        @(negedge clk_sys);
        reset = 1'b0;

        // ZX81 .p image of 3 bytes, immediate ack
        zx81 = 1'b1;
        load_tape(1'b1, 15'd3);
        check("t1_tape_ready", tape_ready, 1);
        check("t1_armed_no_patch", patch_active, 0);
        push_wr(16'h4009, 8'h11);
        push_wr(16'h400A, 8'h22);
        push_wr(16'h400B, 8'h33);
        base = writes_seen;
        m1_fetch(16'h0347);
        check("t1_patch_active", patch_active, 1);
        check_patch("t1_nop_copying", 16'h0348, 8'h00);
        wait_writes("t1_writes", base + 3);
        cycles(2);
        check_patch("t1_scf_done", 16'h0348, 8'h37);
        check_patch("t1_xor_a", 16'h0347, 8'hAF);
        check_patch("t1_jr_disp", 16'h034A, 8'hFD);
        check_patch("t1_jp_lo", 16'h034C, 8'h07);
        check_patch("t1_past_patch", 16'h034E, 8'h00);
        m1_fetch(16'h0349);
        check("t1_inside_keeps", patch_active, 1);
        m1_fetch(16'h03C2);
        check("t1_last_in_window", patch_active, 1);
        m1_fetch(16'h03C3);
        check("t1_exit_clears", patch_active, 0);

        // ZX80 .o image of 2 bytes, re-latched while ARMED
        zx81 = 1'b0;
        load_tape(1'b0, 15'd2);
        push_wr(16'h4000, 8'h11);
        push_wr(16'h4001, 8'h22);
        base = writes_seen;
        m1_fetch(16'h0207);
        check("t2_patch_active", patch_active, 1);
        check_patch("t2_jp_lo_zx80", 16'h020C, 8'h03);
        wait_writes("t2_writes", base + 2);
        cycles(2);
        check_patch("t2_scf_done", 16'h0208, 8'h37);
        m1_fetch(16'h0206);
        check("t2_below_entry_clears", patch_active, 0);

        // Delayed ack: request, address and data held; one write per byte
        zx81      = 1'b1;
        ack_delay = 5;
        load_tape(1'b1, 15'd2);
        push_wr(16'h4009, 8'h11);
        push_wr(16'h400A, 8'h22);
        base = writes_seen;
        m1_fetch(16'h0347);
        wait_writes("t3_writes", base + 2);
        cycles(12);
        check("t3_one_write_per_byte", writes_seen, base + 2);
        m1_fetch(16'h0100);
        check("t3_exit_clears", patch_active, 0);

        // Abort during WRITE, then restart from byte 0
        load_tape(1'b1, 15'd3);
        push_wr(16'h4009, 8'h11);
        base = writes_seen;
        m1_fetch(16'h0347);
        wait_req("t4_req_raised");
        m1_fetch(16'h0100);
        check("t4_req_held", bus.ram_req, 1);
        wait_writes("t4_abort_write", base + 1);
        cycles(1);
        check("t4_req_dropped", bus.ram_req, 0);
        check("t4_abort_clears", patch_active, 0);
        cycles(10);
        check("t4_no_more_writes", writes_seen, base + 1);
        ack_delay = 0;
        push_wr(16'h4009, 8'h11);
        push_wr(16'h400A, 8'h22);
        push_wr(16'h400B, 8'h33);
        m1_fetch(16'h0347);
        wait_writes("t4_restart_writes", base + 4);
        cycles(2);
        m1_fetch(16'h03C3);
        check("t4_exit_clears", patch_active, 0);

        // Empty image: straight to DONE, no write
        load_tape(1'b1, 15'd0);
        base = writes_seen;
        m1_fetch(16'h0347);
        check("t5_patch_active", patch_active, 1);
        check_patch("t5_scf_immediate", 16'h0348, 8'h37);
        cycles(6);
        check("t5_no_req", bus.ram_req, 0);
        check("t5_no_write", writes_seen, base);
        m1_fetch(16'h0100);
        check("t5_exit_clears", patch_active, 0);

        // dl_start while a write is outstanding
        ack_delay = 5;
        load_tape(1'b1, 15'd3);
        m1_fetch(16'h0347);
        wait_req("t6_req_raised");
        @(negedge clk_sys);
        dl_start = 1'b1;
        @(negedge clk_sys);
        dl_start = 1'b0;
        check("t6_req_dropped", bus.ram_req, 0);
        check("t6_patch_cleared", patch_active, 0);
        check("t6_tape_cleared", tape_ready, 0);
        cycles(10);

        // reset in the middle of a copy
        load_tape(1'b1, 15'd3);
        check("t7_tape_ready", tape_ready, 1);
        m1_fetch(16'h0347);
        wait_req("t7_req_raised");
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        check("t7_req_dropped", bus.ram_req, 0);
        check("t7_patch_cleared", patch_active, 0);
        check("t7_tape_cleared", tape_ready, 0);
        check("t7_ram_addr_reset", bus.ram_addr, 0);
        cycles(10);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tape_load_ctrl.md
# tape_load_ctrl

Sequencer for instant tape loading on the ZX80/ZX81 core. It arms when a tape image has been downloaded, detects the CPU fetching the ROM LOAD entry point, and overlays a 7-byte spin-loop patch on the ROM. While the CPU spins, it copies the tape buffer into main SDRAM through a request/acknowledge write port, then releases the CPU by flipping the patch to `scf`. It sits between the tape buffer RAM, the SDRAM write mux and the CPU data-in mux.

## Interface
- `ZX81_ENTRY`, 16'h0347: ZX81 LOAD entry address.
- `ZX81_EXIT`, 16'h03C3: ZX81 first address past the patched window.
- `ZX80_ENTRY`, 16'h0207: ZX80 LOAD entry address.
- `ZX80_EXIT`, 16'h024D: ZX80 first address past the patched window.
- `clk_sys  in  1  system clock (52 MHz)`
- `reset  in  1  synchronous, active-high`
- `zx81  in  1  model: 1 = ZX81, 0 = ZX80; sampled only in ARMED`
- `dl_start  in  1  one-cycle pulse, tape download begins`
- `dl_done  in  1  one-cycle pulse, tape download ended`
- `file_p  in  1  image type, valid at dl_done: 1 = .p (base 16'h4009), 0 = .o (base 16'h4000)`
- `tape_len  in  15  byte count 0..16384, valid at dl_done`
- `cpu_addr  in  16  CPU address bus`
- `cpu_m1_n  in  1  CPU M1, active low`
- `tape_rd_addr  out  14  tape buffer read address; buffer is synchronous, 1-cycle latency`
- `tape_rd_data  in  8  tape buffer read data`
- `ram_addr  out  16  SDRAM write address`
- `ram_din  out  8  SDRAM write data`
- `ram_req  out  1  write request, held until acked`
- `ram_ack  in  1  one-cycle pulse, write accepted`
- `patch_active  out  1  CPU fetches inside the patch window read `patch_byte` instead of ROM`
- `patch_byte  out  8  patch data for the current `cpu_addr` (combinational)`
- `tape_ready  out  1  a tape image is held (drives the LED)`

## Operation
- States and their meaning:
  - IDLE: no tape held.
  - ARMED: tape held, waiting for the entry fetch.
  - FETCH: read address presented to the tape buffer.
  - LATCH: buffer data registered into `ram_din`.
  - WRITE: `ram_req` high, waiting for `ram_ack`.
  - DONE: copy complete, waiting for the CPU to leave the window.
- An M1 event is a falling edge of `cpu_m1_n`, detected against a registered copy.
- Transitions:
  - IDLE → ARMED on `dl_done`. Latch `file_p` and `tape_len`; set `tape_ready`.
  - ARMED → FETCH on an M1 event with `cpu_addr` == ENTRY (ZX81 or ZX80 value per `zx81`).
    - Clear the byte counter `n`, latch the model, set `patch_active`.
    - If `tape_len` == 0, go to DONE instead.
  - FETCH → LATCH → WRITE, one cycle each.
  - WRITE → (`ram_ack`): increment `n`. If `n+1` == `tape_len`, go to DONE; otherwise go to FETCH.
  - FETCH, LATCH, WRITE or DONE, on an M1 event with `cpu_addr` ≥ EXIT or < ENTRY:
    - Abort and go to ARMED; clear `patch_active`.
    - If the state is WRITE, hold `ram_req` until `ram_ack` before leaving.
  - Any state → IDLE on `dl_start`: clear `tape_ready` and drop `ram_req`. `dl_start` wins over every other event in the same cycle.
- Address generation:
  - `tape_rd_addr` = `n[13:0]`.
  - `ram_addr` = base + `n`, 16-bit wrap.
- Patch bytes, indexed by `cpu_addr` − ENTRY:
  - 0: AF (`xor a`).
  - 1: 00 (`nop`) while copying; 37 (`scf`) in DONE.
  - 2: 30, 3: FD (`jr nc,-3`).
  - 4: C3 (`jp`).
  - 5: 07 on ZX81, 03 on ZX80.
  - 6: 02.
  - Any other index reads 00.
- `patch_active` is high from ARMED→FETCH (or →DONE) until the exit/abort transition.

## Timing
- Reset values:
  - State IDLE.
  - `tape_ready`, `patch_active`, `ram_req` all 0.
  - `n`, `tape_rd_addr`, `ram_addr`, `ram_din` all 0.
  - Registered M1 copy = 1.
- An entry M1 event seen at edge k gives `patch_active` = 1 after edge k+1.
- Per byte: FETCH 1 cycle, LATCH 1 cycle, WRITE ≥1 cycle. Minimum is 3 cycles per byte with `ram_ack` returned in the first WRITE cycle.
- `ram_addr` and `ram_din` are stable for the whole time `ram_req` is high. `ram_req` falls on the edge after `ram_ack`.
- `ram_ack` arriving outside WRITE is ignored.
- `patch_byte` is combinational from `cpu_addr` and the state. The byte-1 change to 37 is visible in the cycle after entering DONE.
- A `dl_done` arriving in ARMED re-latches `tape_len` and `file_p`.

## Structure
- Shared package `zx8x_pkg` holds:
  - the state enum `tl_state_t`;
  - entry/exit address constants;
  - the .o/.p base constants;
  - the patch opcode constants.
- No sub-module. Single FSM plus counter. The patch ROM is a `case` on the offset.

## Test plan
- ZX81, .p, `tape_len`=3, `ram_ack` immediate, M1 at 0347 → writes to 4009/400A/400B with buffer bytes 0..2. `patch_byte` at 0348 reads 00 during the copy and 37 after.
- ZX80, .o, `tape_len`=2 → writes to 4000/4001; `patch_byte` at 020C (offset 5) = 03.
- `ram_ack` delayed 5 cycles → `ram_req`, `ram_addr` and `ram_din` held constant; exactly one write per byte.
- Copy aborted by M1 at 0100 during WRITE → `ram_req` held until ack, then ARMED. A second M1 at 0347 restarts from `n`=0.
- `tape_len`=0 → ARMED→DONE, no `ram_req`; `patch_byte` at 0348 = 37.
- `dl_start` during WRITE, and `reset` mid-copy → next cycle IDLE with `ram_req`=0, `patch_active`=0, `tape_ready`=0.
